// File: rtl/pc_word_pkg.sv
// Shared PC-bound word encoding: type codes, field widths and source index type.
// Used by both the packer and the PC-side parser.
package pc_word_pkg;

  localparam int ROUTE_W = 6;
  localparam int SEQ_W   = 16;

  localparam logic [1:0]         CODE_BD  = 2'b00;
  localparam logic [1:0]         CODE_HB  = 2'b10;
  localparam logic [1:0]         CODE_RPT = 2'b11;
  localparam logic [ROUTE_W-1:0] HB_ROUTE = 6'h3F;

  // Source 0 is BD, sources 1..Nchan are report channels 0..Nchan-1.
  typedef logic [ROUTE_W-1:0] src_idx_t;

endpackage

// File: rtl/pc_out_fifo.sv
// Two-entry output FIFO; head register drives the output directly.
// Simultaneous push/pop keeps occupancy and ordering intact.
module pc_out_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head, tail;
  logic [1:0]       count;
  logic             do_push, do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_packer.sv
// Merges BD words, FPGA report channels and idle heartbeats into one PC-bound
// word stream via round-robin arbitration and a 2-entry output FIFO.
module pc_packer
  import pc_word_pkg::*;
#(
  parameter int         NPCout    = 32,
  parameter int         NBDdata   = 20,
  parameter int         Nconf     = 16,
  parameter int         Nchan     = 2,
  parameter int         HB_PERIOD = 1024,
  parameter logic [15:0] SEQ_RESET = 16'h0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        BD_in_v,
  input  logic [ROUTE_W-1:0]          BD_in_route,
  input  logic [NBDdata-1:0]          BD_in_payload,
  output logic                        BD_in_a,
  input  logic [Nchan-1:0]            rpt_v,
  input  logic [Nchan-1:0][Nconf-1:0] rpt_d,
  output logic [Nchan-1:0]            rpt_a,
  output logic                        PC_out_v,
  output logic [NPCout-1:0]           PC_out_d,
  input  logic                        PC_out_a
);

  localparam int NSRC = Nchan + 1;
  localparam int CW   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [CW-1:0] IDLE_MAX = CW'((HB_PERIOD > 0) ? HB_PERIOD - 1 : 0);

  logic [NSRC-1:0]   src_v;
  src_idx_t          start, gnt, ch;
  logic              found, gnt_v, space, hb_due, hb_push, push;
  logic              full, empty;
  logic [NPCout-1:0] bd_word, rpt_word, hb_word, push_d;
  logic [CW-1:0]     idle;
  logic [SEQ_W-1:0]  seq;

  assign src_v = {rpt_v, BD_in_v};
  // Gating with reset keeps every accept low while reset is held.
  assign space = !reset && (!full || PC_out_a);

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && src_v[(int'(start) + k) % NSRC]) begin
        found = 1'b1;
        gnt   = src_idx_t'((int'(start) + k) % NSRC);
      end
    end
  end

  assign gnt_v   = found && space;
  assign hb_due  = (HB_PERIOD != 0) && (idle == IDLE_MAX);
  assign hb_push = hb_due && !(|src_v) && space;
  assign push    = gnt_v || hb_push;
  assign ch      = (gnt == '0) ? '0 : gnt - src_idx_t'(1);

  assign BD_in_a = gnt_v && (gnt == '0);
  for (genvar i = 0; i < Nchan; i++) begin : g_rpt_a
    assign rpt_a[i] = gnt_v && (gnt == src_idx_t'(i + 1));
  end

  always_comb begin
    bd_word = '0;
    bd_word[NPCout-1 -: 2]       = CODE_BD;
    bd_word[NPCout-3 -: ROUTE_W] = BD_in_route;
    bd_word[NBDdata-1:0]         = BD_in_payload;
    rpt_word = '0;
    rpt_word[NPCout-1 -: 2]       = CODE_RPT;
    rpt_word[NPCout-3 -: ROUTE_W] = ch;
    rpt_word[Nconf-1:0]           = rpt_d[ch];
    hb_word = '0;
    hb_word[NPCout-1 -: 2]       = CODE_HB;
    hb_word[NPCout-3 -: ROUTE_W] = HB_ROUTE;
    hb_word[SEQ_W-1:0]           = seq;
    if (!gnt_v)          push_d = hb_word;
    else if (gnt == '0)  push_d = bd_word;
    else                 push_d = rpt_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start <= '0;
      idle  <= '0;
      seq   <= SEQ_RESET;
    end else begin
      if (gnt_v) start <= (gnt == src_idx_t'(NSRC - 1)) ? '0 : gnt + src_idx_t'(1);
      if (push)                  idle <= '0;
      else if (idle != IDLE_MAX) idle <= idle + CW'(1);
      if (hb_push) seq <= seq + SEQ_W'(1);
    end
  end

  pc_out_fifo #(.WIDTH(NPCout)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_d),
    .pop   (PC_out_a),
    .dout  (PC_out_d),
    .full  (full),
    .empty (empty)
  );

  assign PC_out_v = !empty;

endmodule

// File: doc/pc_packer.md
PC_PACKER -- requirements
Module: pc_packer

Interface
REQ-001 SHALL have parameter NPCout, default 32, meaning PC-bound word width.
REQ-002 SHALL have parameter NBDdata, default 20, meaning BD payload width.
REQ-003 SHALL have parameter Nconf, default 16, meaning FPGA report data width.
REQ-004 SHALL have parameter Nchan, default 2, meaning number of FPGA report channels (1..63).
REQ-005 SHALL have parameter HB_PERIOD, default 1024, meaning idle cycles before a heartbeat word; 0 disables heartbeats.
REQ-006 SHALL have port clk, input, 1, meaning the rising-edge clock.
REQ-007 SHALL have port reset, input, 1, meaning reset: asynchronous, active-high.
REQ-008 SHALL have port BD_in_v, input, 1, meaning the BD-originated word is valid.
REQ-009 SHALL have port BD_in_route, input, 6, meaning the BD route/leaf code.
REQ-010 SHALL have port BD_in_payload, input, NBDdata, meaning the BD payload.
REQ-011 SHALL have port BD_in_a, output, 1, meaning BD word accepted.
REQ-012 SHALL have port rpt_v, input, Nchan, meaning per-channel report valid.
REQ-013 SHALL have port rpt_d, input, Nchan x Nconf, meaning per-channel report data.
REQ-014 SHALL have port rpt_a, output, Nchan, meaning per-channel report accepted.
REQ-015 SHALL have port PC_out_v, output, 1, meaning the PC-bound word is valid.
REQ-016 SHALL have port PC_out_d, output, NPCout, meaning the PC-bound word.
REQ-017 SHALL have port PC_out_a, input, 1, meaning PC consumer accepts the word.

Function
REQ-018 SHALL treat a transfer on any channel as occurring at a rising clk edge where its v and a are both high.
REQ-019 SHALL format BD words MSB to LSB as {1'b0, 1'b0, route[5:0], 4'b0, payload[19:0]}.
REQ-020 SHALL format report channel i as {1'b1, 1'b1, i[5:0], 8'b0, data[15:0]}.
REQ-021 SHALL format heartbeats as {1'b1, 1'b0, 6'h3F, 8'b0, seq[15:0]}; all unused bits SHALL be 0.
REQ-022 SHALL buffer output words in a 2-entry FIFO; PC_out_v SHALL equal FIFO non-empty, and PC_out_d SHALL be the FIFO head.
REQ-023 SHALL arbitrate sources 0 (BD) through Nchan (rpt 0..Nchan-1) round-robin, granting at most one source per cycle.
REQ-024 SHALL start the grant search at the source after the last granted source.
REQ-025 SHALL assert the granted source's a combinationally in the same cycle only when the FIFO is not full, or is full with PC_out_a high; all other a outputs SHALL be 0.
REQ-026 SHALL never assert an a output whose v is low.
REQ-027 SHALL have latency 1: a word accepted at edge t SHALL appear on PC_out when the FIFO was empty, sustaining 1 word/cycle while PC_out_a stays high.
REQ-028 SHALL handle simultaneous FIFO push and pop with the occupancy unchanged and order preserved.
REQ-029 SHALL keep an idle counter that clears on any source acceptance and otherwise increments, saturating at HB_PERIOD-1.
REQ-030 SHALL push one heartbeat when the idle counter equals HB_PERIOD-1, no source is valid, and the FIFO has space, then clear the counter.
REQ-031 SHALL let any valid source pre-empt a due heartbeat.
REQ-032 SHALL increment the 16-bit heartbeat seq after each heartbeat push, wrapping 0xFFFF to 0x0000.
REQ-033 SHALL hold PC_out_d stable while PC_out_v=1 and PC_out_a=0.

Reset
REQ-034 SHALL, while reset=1, empty the FIFO, hold PC_out_v=0, BD_in_a=0 and rpt_a=0, set the round-robin pointer to source 0, and set seq and the idle counter to 0.
REQ-035 SHALL discard buffered words when reset is asserted mid-operation, with no partial word emitted after reset release.

Structure
REQ-036 SHALL place the word codes (BD=2'b00, heartbeat=2'b10/6'h3F, report=2'b11), the field widths, and the source-index typedef in shared package pc_word_pkg, which the PC parser also uses.
REQ-037 SHALL implement the 2-entry FIFO as sub-module pc_out_fifo, with parameters for width and push/pop/full/empty.

Verification
REQ-038 Bench SHALL cover: BD_in route=6'h05, payload=20'hABCDE, PC_out_a=1 -> PC_out_d=32'h050ABCDE one cycle later.
REQ-039 Bench SHALL cover: rpt_v=2'b10, rpt_d[1]=16'h1234 -> PC_out_d=32'hC1001234, with rpt_a[1] pulsed for exactly 1 cycle.
REQ-040 Bench SHALL cover: all three sources held valid, PC_out_a=1 -> grant order BD, rpt0, rpt1, BD, ... at 1 word/cycle.
REQ-041 Bench SHALL cover: PC_out_a=0 with BD streaming -> exactly 2 words accepted, then BD_in_a=0 and PC_out_d stable; on release, words arrive in order with no loss.
REQ-042 Bench SHALL cover: HB_PERIOD=8, no inputs -> heartbeat 32'hBF000000 after 8 idle cycles, then 32'hBF000001 8 cycles later; seq preset to 0xFFFF wraps to 0x0000.
REQ-043 Bench SHALL cover: reset pulsed with 2 words buffered -> PC_out_v=0 immediately, with no stale word after release.
